wasm_fetch: RTL and testbench

WASM_FETCH -- requirements
Module: wasm_fetch

---
 rtl/wasm_pkg.sv | 37 +++
 rtl/leb128_decoder.sv | 53 +++++
 rtl/wasm_fetch.sv | 124 ++++++++++++
 tb/tb_wasm_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_pkg.sv
//==============================================================================
// Module   : wasm_pkg
// Brief    : Shared WebAssembly opcode constants, LEB128 limits and fetch states.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package wasm_pkg;

   localparam logic [7:0] OP_END       = 8'h0B;
   localparam logic [7:0] OP_BR        = 8'h0C;
   localparam logic [7:0] OP_BR_IF     = 8'h0D;
   localparam logic [7:0] OP_CALL      = 8'h10;
   localparam logic [7:0] OP_LOCAL_GET = 8'h20;
   localparam logic [7:0] OP_LOCAL_SET = 8'h21;
   localparam logic [7:0] OP_LOCAL_TEE = 8'h22;
   localparam logic [7:0] OP_I32_CONST = 8'h41;

   localparam logic [7:0] CODE_BASE     = 8'h30;
   localparam int         LEB_MAX_BYTES = 5;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH_OP  = 3'd1,
      ST_FETCH_IMM = 3'd2,
      ST_EMIT      = 3'd3,
      ST_ERROR     = 3'd4
   } fetch_state_t;

   function automatic logic op_has_imm(input logic [7:0] op);
      return op inside {OP_BR, OP_BR_IF, OP_CALL, OP_LOCAL_GET,
                        OP_LOCAL_SET, OP_LOCAL_TEE, OP_I32_CONST};
   endfunction

endpackage

`default_nettype wire

// File: rtl/leb128_decoder.sv
//==============================================================================
// Module   : leb128_decoder
// Brief    : Byte-serial LEB128 accumulator (signed/unsigned) with overlong detect.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module leb128_decoder
   import wasm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   input  logic        is_signed,
   output logic [31:0] acc,
   output logic        done,
   output logic        overflow
);

   localparam logic [2:0] LAST_IDX = 3'(LEB_MAX_BYTES - 1);

   logic [31:0] r_acc;
   logic [2:0]  r_idx;
   logic [5:0]  w_shift;
   logic [31:0] w_merged;

   // acc already includes the current byte so the final value is usable on done
   always_comb begin
      w_shift  = 6'(r_idx) * 6'd7;
      w_merged = r_acc | ({25'd0, byte_in[6:0]} << w_shift);
      acc      = w_merged;
      if (is_signed && !byte_in[7] && byte_in[6] && (r_idx < LAST_IDX))
         acc = w_merged | (32'hFFFF_FFFF << (w_shift + 6'd7));
   end

   assign done     = byte_valid && !byte_in[7];
   assign overflow = byte_valid && byte_in[7] && (r_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (byte_valid && byte_in[7] && !overflow) begin
         r_acc <= w_merged;
         r_idx <= r_idx + 3'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wasm_fetch.sv
//==============================================================================
// Module   : wasm_fetch
// Brief    : WebAssembly opcode + LEB128 immediate fetch unit; redirect support
//            is compiled in only when WASM_FETCH_REDIRECT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wasm_fetch
   import wasm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_mapped,
   input  logic [31:0] first_instruction,
   output logic [31:0] mem_addr,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_out,
   input  logic        mem_ready,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [7:0]  insn_opcode,
   output logic [31:0] insn_imm,
   output logic [31:0] insn_pc,
   input  logic        redirect_en,
   input  logic [31:0] redirect_addr,
   output logic        fetch_error
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         w_redirect;
   logic         w_byte;
   logic         w_imm_byte;
   logic         w_leb_clear;
   logic [31:0]  w_leb_acc;
   logic         w_leb_done;
   logic         w_leb_ovf;

`ifdef WASM_FETCH_REDIRECT_EN
   assign w_redirect = redirect_en &&
                       (r_state inside {ST_FETCH_OP, ST_FETCH_IMM, ST_EMIT});
`else
   logic w_unused_redirect;
   assign w_unused_redirect = redirect_en ^ (^redirect_addr);
   assign w_redirect        = 1'b0;
`endif

   assign mem_read_en = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_IMM);
   assign mem_addr    = r_pc;
   assign insn_valid  = (r_state == ST_EMIT);

   // A byte arriving alongside a redirect belongs to the abandoned stream
   assign w_byte      = mem_read_en && mem_ready && !w_redirect;
   assign w_imm_byte  = w_byte && (r_state == ST_FETCH_IMM);
   assign w_leb_clear = (r_state != ST_FETCH_IMM) || w_redirect;

   leb128_decoder u_leb (
      .clk        (clk),
      .rst        (rst),
      .clear      (w_leb_clear),
      .byte_valid (w_imm_byte),
      .byte_in    (mem_data_out),
      .is_signed  (insn_opcode == OP_I32_CONST),
      .acc        (w_leb_acc),
      .done       (w_leb_done),
      .overflow   (w_leb_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pc        <= '0;
         insn_opcode <= '0;
         insn_imm    <= '0;
         insn_pc     <= '0;
         fetch_error <= 1'b0;
      end else if (w_redirect) begin
         r_pc    <= redirect_addr;
         r_state <= ST_FETCH_OP;
      end else begin
         if (w_byte)
            r_pc <= r_pc + 32'd1;
         case (r_state)
            ST_IDLE: begin
               if (rom_mapped) begin
                  r_pc    <= first_instruction;
                  r_state <= ST_FETCH_OP;
               end
            end
            ST_FETCH_OP: begin
               if (w_byte) begin
                  insn_opcode <= mem_data_out;
                  insn_pc     <= r_pc;
                  if (op_has_imm(mem_data_out)) begin
                     r_state <= ST_FETCH_IMM;
                  end else begin
                     insn_imm <= '0;
                     r_state  <= ST_EMIT;
                  end
               end
            end
            ST_FETCH_IMM: begin
               if (w_leb_ovf) begin
                  fetch_error <= 1'b1;
                  r_state     <= ST_ERROR;
               end else if (w_leb_done) begin
                  insn_imm <= w_leb_acc;
                  r_state  <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (insn_ready)
                  r_state <= ST_FETCH_OP;
            end
            ST_ERROR: r_state <= ST_ERROR;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wasm_fetch.sv
//==============================================================================
// Module   : tb_wasm_fetch
// Brief    : Directed and randomized self-checking bench for wasm_fetch.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wasm_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_mapped = 1'b0;
   logic [31:0] first_instruction = 32'h30;
   logic [31:0] mem_addr;
   logic        mem_read_en;
   logic [7:0]  mem_data_out = 8'h00;
   logic        mem_ready = 1'b0;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic [7:0]  insn_opcode;
   logic [31:0] insn_imm;
   logic [31:0] insn_pc;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        fetch_error;

   logic [7:0]  mem [256];
   int          vectors = 0;
   int          miscompares = 0;
   bit          auto_mem = 1'b1;
   bit          rand_ready = 1'b0;
   bit          model_on = 1'b0;

   always #5 clk = ~clk;

   wasm_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .rom_mapped        (rom_mapped),
      .first_instruction (first_instruction),
      .mem_addr          (mem_addr),
      .mem_read_en       (mem_read_en),
      .mem_data_out      (mem_data_out),
      .mem_ready         (mem_ready),
      .insn_valid        (insn_valid),
      .insn_ready        (insn_ready),
      .insn_opcode       (insn_opcode),
      .insn_imm          (insn_imm),
      .insn_pc           (insn_pc),
      .redirect_en       (redirect_en),
      .redirect_addr     (redirect_addr),
      .fetch_error       (fetch_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decode straight from the instruction-format rules
   function automatic void ref_decode(input logic [31:0] pc, output logic [7:0] op,
                                      output logic [31:0] imm, output logic [31:0] len,
                                      output bit err);
      longint     v;
      int         n;
      bit         fin;
      logic [7:0] b;
      logic [31:0] a;
      op = mem[pc[7:0]]; imm = 0; len = 1; err = 0;
      if (op inside {8'h0C, 8'h0D, 8'h10, 8'h20, 8'h21, 8'h22, 8'h41}) begin
         v = 0; n = 0; fin = 0; b = 0;
         while (!fin && n < 5) begin
            a = pc + len;
            b = mem[a[7:0]];
            len++;
            v += longint'(b & 8'h7F) << (7 * n);
            n++;
            if (!b[7]) fin = 1;
         end
         err = !fin;
         if (fin && op == 8'h41 && b[6] && 7 * n < 32)
            v -= longint'(1) << (7 * n);
         imm = v[31:0];
      end
   endfunction

   // Memory responder with random latency, plus random consumer back-pressure
   initial forever begin
      @(posedge clk); #1;
      if (auto_mem) begin
         if (mem_read_en && $urandom_range(3) != 0) begin
            mem_ready    = 1'b1;
            mem_data_out = mem[mem_addr[7:0]];
         end else begin
            mem_ready    = 1'b0;
            mem_data_out = 8'($urandom);
         end
      end
      if (rand_ready) insn_ready = ($urandom_range(1) == 1);
   end

   // Continuous comparison against the reference during the randomized phase
   initial begin
      logic [31:0] model_pc, eimm, elen;
      logic [7:0]  eop;
      bit          eerr;
      int          stall;
      model_pc = 0; stall = 0;
      forever begin
         @(negedge clk);
         if (rst || !model_on) begin
            model_pc = first_instruction;
            stall = 0;
         end else begin
            ref_decode(model_pc, eop, eimm, elen, eerr);
            if (insn_valid) begin
               stall = 0;
               check("rand_unexpected_insn", 32'(eerr), 32'd0);
               check("rand_opcode", 32'(insn_opcode), 32'(eop));
               check("rand_imm", insn_imm, eimm);
               check("rand_pc", insn_pc, model_pc);
               check("rand_no_read_in_emit", 32'(mem_read_en), 32'd0);
               if (insn_ready) model_pc += elen;
            end else if (fetch_error) begin
               stall = 0;
               check("rand_error_legit", 32'(eerr), 32'd1);
            end else begin
               stall++;
               if (stall > 60) begin
                  check("rand_progress_timeout", 32'(stall), 32'd0);
                  stall = 0;
               end
            end
         end
      end
   end

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic gen_program(input logic [7:0] start);
      int a;
      a = int'(start);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 30; i++) begin
         int         sel;
         int         len;
         logic [7:0] op;
         logic [7:0] b;
         sel = $urandom_range(9);
         case (sel)
            0: op = 8'h6A;
            1: op = 8'h0B;
            2: op = 8'h01;
            3: op = 8'h45;
            4: op = 8'h0C;
            5: op = 8'h0D;
            6: op = 8'h10;
            7: op = 8'(8'h20 + $urandom_range(2));
            default: op = 8'h41;
         endcase
         mem[a[7:0]] = op; a++;
         if (sel >= 4) begin
            len = ($urandom_range(15) == 0) ? 6 : $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
               b = 8'($urandom);
               b[7] = (j != len - 1);
               mem[a[7:0]] = b; a++;
            end
         end
      end
   endtask

   task automatic do_reset(input logic [31:0] start);
      @(posedge clk); #1;
      rst = 1'b1; rom_mapped = 1'b0; redirect_en = 1'b0;
      first_instruction = start; auto_mem = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; rom_mapped = 1'b1;
   endtask

   task automatic wait_valid(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (insn_valid) begin ok = 1; break; end
      end
      if (!ok) check(name, 32'(insn_valid), 32'd1);
   endtask

   task automatic handshake();
      insn_ready = 1'b1;
      @(posedge clk); #1 insn_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},  32'(insn_valid), 32'd0);
      check({tag, "_read"},   32'(mem_read_en), 32'd0);
      check({tag, "_addr"},   mem_addr, 32'd0);
      check({tag, "_opcode"}, 32'(insn_opcode), 32'd0);
      check({tag, "_imm"},    insn_imm, 32'd0);
      check({tag, "_pc"},     insn_pc, 32'd0);
      check({tag, "_error"},  32'(fetch_error), 32'd0);
   endtask

   initial begin
      bit ok;
      bit seen;
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      bit seen;
      fill_mem(8'h01);
      @(negedge clk);
      check_reset_outputs("reset");

      // i32.const with one-byte negative immediate
      mem[8'h30] = 8'h41; mem[8'h31] = 8'h7F;
      do_reset(32'h30);
      wait_valid("t1_valid", ok);
      check("t1_opcode", 32'(insn_opcode), 32'h41);
      check("t1_imm", insn_imm, 32'hFFFF_FFFF);
      check("t1_pc", insn_pc, 32'h30);
      handshake();

      // local.get with 3-byte immediate, next read at +4
      fill_mem(8'h01);
      mem[8'h30] = 8'h20; mem[8'h31] = 8'hE5; mem[8'h32] = 8'h8E; mem[8'h33] = 8'h26;
      do_reset(32'h30);
      wait_valid("t2_valid", ok);
      check("t2_opcode", 32'(insn_opcode), 32'h20);
      check("t2_imm", insn_imm, 32'd624485);
      check("t2_pc", insn_pc, 32'h30);
      handshake();
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_read_en) begin ok = 1; break; end
      end
      check("t2_next_read", 32'(ok), 32'd1);
      check("t2_next_addr", mem_addr, 32'h34);

      // back-pressure: held and stable, exactly one transfer
      fill_mem(8'h01);
      mem[8'h30] = 8'h6A;
      do_reset(32'h30);
      wait_valid("t3_valid", ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(insn_valid), 32'd1);
         check("t3_hold_opcode", 32'(insn_opcode), 32'h6A);
         check("t3_hold_imm", insn_imm, 32'd0);
         check("t3_hold_pc", insn_pc, 32'h30);
      end
      handshake();
      @(negedge clk);
      check("t3_single_transfer", 32'(insn_valid), 32'd0);

      // overlong immediate
      fill_mem(8'h80);
      mem[8'h30] = 8'h41;
      do_reset(32'h30);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (insn_valid) seen = 1;
         if (fetch_error) break;
      end
      check("t4_error", 32'(fetch_error), 32'd1);
      check("t4_no_valid", 32'(seen), 32'd0);
      repeat (4) @(negedge clk);
      check("t4_error_sticky", 32'(fetch_error), 32'd1);
      check("t4_no_read", 32'(mem_read_en), 32'd0);
      check("t4_still_no_valid", 32'(insn_valid), 32'd0);

      // redirect while fetching the immediate
      fill_mem(8'h01);
      mem[8'h30] = 8'h20; mem[8'h31] = 8'h85; mem[8'h32] = 8'h01; mem[8'h40] = 8'h6A;
      do_reset(32'h30);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_read_en && mem_addr == 32'h31) begin ok = 1; break; end
      end
      check("t5_reach_imm", 32'(ok), 32'd1);
      redirect_en = 1'b1; redirect_addr = 32'h40;
      @(posedge clk); #1 redirect_en = 1'b0;
      @(negedge clk);
`ifdef WASM_FETCH_REDIRECT_EN
      check("t5_redirect_read", 32'(mem_read_en), 32'd1);
      check("t5_redirect_addr", mem_addr, 32'h40);
      wait_valid("t5_valid", ok);
      check("t5_opcode", 32'(insn_opcode), 32'h6A);
      check("t5_imm", insn_imm, 32'd0);
      check("t5_pc", insn_pc, 32'h40);
`else
      wait_valid("t5_valid", ok);
      check("t5_opcode", 32'(insn_opcode), 32'h20);
      check("t5_imm", insn_imm, 32'd133);
      check("t5_pc", insn_pc, 32'h30);
`endif
      handshake();

      // reset while a read is pending; late mem_ready must be ignored
      fill_mem(8'h01);
      mem[8'h30] = 8'h41; mem[8'h31] = 8'h7F;
      do_reset(32'h30);
      wait_valid("t6_valid", ok);
      auto_mem = 1'b0; mem_ready = 1'b0;
      handshake();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rom_mapped = 1'b0; mem_ready = 1'b1; mem_data_out = 8'h41;
      @(negedge clk);
      check_reset_outputs("t6a");
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6b");
      auto_mem = 1'b1;

      // randomized programs against the reference decoder
      model_on = 1'b1; rand_ready = 1'b1;
      for (int s = 0; s < 30; s++) begin
         logic [31:0] start;
         start = (s % 3 == 0) ? 32'hFFFF_FFF0 : (($urandom & 32'hFFFF_FF00) | 32'h30);
         @(posedge clk); #1 rst = 1'b1;
         gen_program(start[7:0]);
         do_reset(start);
         for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (fetch_error) break;
         end
         repeat (3) @(negedge clk);
      end
      model_on = 1'b0; rand_ready = 1'b0; insn_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
